mod_cnt_tick: RTL



---
 rtl/cnt_pkg.sv | 23 ++
 rtl/mod_cnt_tick_if.sv | 31 +++
 rtl/tick_gen.sv | 48 ++++
 rtl/mod_cnt_tick.sv | 96 +++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared constants for the watch counter chain (sec/min/hour) and the tick generators.
package cnt_pkg;

  localparam int unsigned SEC_MOD  = 60;
  localparam int unsigned MIN_MOD  = 60;
  localparam int unsigned HOUR_MOD = 24;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned NUM_1HZ = CLK_HZ;

  // Minimum counter widths for each stage of the chain.
  localparam int unsigned SEC_W  = $clog2(SEC_MOD);
  localparam int unsigned MIN_W  = $clog2(MIN_MOD);
  localparam int unsigned HOUR_W = $clog2(HOUR_MOD);

  // True when a modulus is usable with a counter of the given width.
  function automatic bit mod_fits(input int unsigned modulus, input int unsigned width);
    longint unsigned m;
    m = longint'(modulus);
    return (m >= 64'd2) && (m <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/mod_cnt_tick_if.sv
// Control/status bundle of one modulo counter stage.
interface mod_cnt_tick_if
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned NCO_W = 32
);

  logic [NCO_W-1:0] num;
  logic             ext_sel;
  logic             ext_tick;
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tick_o;
  logic             carry_o;

  modport master (
    output num, ext_sel, ext_tick, en, up_dn, clr, load, load_val,
    input  out, tick_o, carry_o
  );

  modport slave (
    input  num, ext_sel, ext_tick, en, up_dn, clr, load, load_val,
    output out, tick_o, carry_o
  );

endinterface

// File: rtl/tick_gen.sv
// NCO tick generator: one-cycle enable pulse every max(num,1) clk cycles.
module tick_gen
  import cnt_pkg::*;
#(
  parameter int unsigned NCO_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCO_W-1:0] num,
  input  logic             en,
  input  logic             hold_zero,
  input  logic             clr,
  output logic             tick
);

  logic [NCO_W-1:0] nco_cnt_q, nco_cnt_d;
  logic [NCO_W-1:0] num_eff;
  logic [NCO_W-1:0] thresh;

  // Tick decode; >= lets a shrunken num fire on the very next edge.
  always_comb begin
    num_eff = (num == '0) ? NCO_W'(1) : num;
    thresh  = num_eff - NCO_W'(1);
    tick    = en & ~hold_zero & (nco_cnt_q >= thresh);
  end

  // Next NCO count: clear/hold-zero, restart on tick, count while enabled.
  always_comb begin
    nco_cnt_d = nco_cnt_q;
    if (clr || hold_zero) begin
      nco_cnt_d = '0;
    end else if (tick) begin
      nco_cnt_d = '0;
    end else if (en) begin
      nco_cnt_d = nco_cnt_q + NCO_W'(1);
    end
  end

  // NCO counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nco_cnt_q <= '0;
    end else begin
      nco_cnt_q <= nco_cnt_d;
    end
  end

endmodule

// File: rtl/mod_cnt_tick.sv
// Modulo-MOD up/down counter with load, sync clear and carry, advanced by an NCO or ext_tick.
module mod_cnt_tick
  import cnt_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MOD   = 60,
  parameter int unsigned NCO_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_cnt_tick_if.slave bus
);

  if (!mod_fits(MOD, WIDTH)) begin : g_bad_mod
    $error("mod_cnt_tick: MOD=%0d does not fit WIDTH=%0d", MOD, WIDTH);
  end

  // Range compares use one extra bit since the modulus may equal 2**WIDTH.
  localparam logic [WIDTH:0]   ModExt  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   TopExt  = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MOD - 1);

  logic             tick_nco;
  logic             adv;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             carry_q, carry_d;

  tick_gen #(
    .NCO_W(NCO_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .num      (bus.num),
    .en       (bus.en),
    .hold_zero(bus.ext_sel),
    .clr      (bus.clr),
    .tick     (tick_nco)
  );

  // Advance source select and load clamp.
  always_comb begin
    adv          = bus.ext_sel ? (bus.en & bus.ext_tick) : tick_nco;
    load_clamped = ({1'b0, bus.load_val} >= ModExt) ? MaxVal : bus.load_val;
  end

  // Next count and pulses: clr > load > adv > hold.
  always_comb begin
    out_d   = out_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    if (bus.clr) begin
      out_d = '0;
    end else if (bus.load) begin
      out_d  = load_clamped;
      tick_d = adv;
    end else if (adv) begin
      tick_d = 1'b1;
      if (bus.up_dn) begin
        if ({1'b0, out_q} >= TopExt) begin
          out_d   = '0;
          carry_d = 1'b1;
        end else begin
          out_d = out_q + WIDTH'(1);
        end
      end else begin
        // Out-of-range values (only reachable by forcing) also snap to MOD-1.
        if (out_q == '0 || {1'b0, out_q} >= ModExt) begin
          out_d   = MaxVal;
          carry_d = 1'b1;
        end else begin
          out_d = out_q - WIDTH'(1);
        end
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.tick_o  = tick_q;
  assign bus.carry_o = carry_q;

endmodule
